// File: rtl/decode_stage.sv
// Decode stage: classifies the fetched instruction, reads and forwards register
// operands, keeps a pending-write scoreboard and redirects fetch on JR/JALR.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'hfffffffc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        done,
    input  logic [31:0] pc_in,
    input  logic [31:0] command,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        wb_enable,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic [3:0]  opclass,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd_addr,
    output logic        reg_write,
    output logic [31:0] src_a,
    output logic [31:0] src_b,
    output logic [31:0] imm,
    output logic        pcenable,
    output logic [31:0] next_pc
);

    // state | meaning
    // IDLE  | waiting for enable; captures pc_in and command
    // CHECK | scoreboard check of the used sources; issues once none is hazardous
    typedef enum logic {IDLE, CHECK} state_t;

    localparam logic [3:0] OC_NOP     = 4'd0;
    localparam logic [3:0] OC_ALU_R   = 4'd1;
    localparam logic [3:0] OC_ALU_I   = 4'd2;
    localparam logic [3:0] OC_LUI     = 4'd3;
    localparam logic [3:0] OC_LOAD    = 4'd4;
    localparam logic [3:0] OC_STORE   = 4'd5;
    localparam logic [3:0] OC_BRANCH  = 4'd6;
    localparam logic [3:0] OC_JUMP    = 4'd7;
    localparam logic [3:0] OC_JREG    = 4'd8;
    localparam logic [3:0] OC_ILLEGAL = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;

    state_t      state;
    logic [31:0] cmd_q;
    logic [31:0] pc_q;
    logic [31:0] busy;
    logic [31:0] busy_n;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd_f;
    logic [31:0] sext16;
    logic [31:0] zext16;

    logic [3:0]  d_class;
    logic [3:0]  d_alu;
    logic [4:0]  d_rd;
    logic        d_dest;
    logic        d_write;
    logic [31:0] d_imm;
    logic        use_rs;
    logic        use_rt;
    logic        d_shift;
    logic [3:0]  r_alu;
    logic        r_ok;

    logic        fwd_rs;
    logic        fwd_rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hazard;
    logic        issue;

    assign opcode  = cmd_q[31:26];
    assign funct   = cmd_q[5:0];
    assign rd_f    = cmd_q[15:11];
    assign rs_addr = cmd_q[25:21];
    assign rt_addr = cmd_q[20:16];
    assign sext16  = {{16{cmd_q[15]}}, cmd_q[15:0]};
    assign zext16  = {16'h0, cmd_q[15:0]};

    always_comb begin
        r_alu = ALU_ADD;
        r_ok  = 1'b1;
        case (funct)
            6'b100001: r_alu = ALU_ADD;
            6'b100011: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            6'b000000: r_alu = ALU_SLL;
            6'b000010: r_alu = ALU_SRL;
            default:   r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        d_class = OC_ILLEGAL;
        d_alu   = ALU_ADD;
        d_rd    = 5'd0;
        d_dest  = 1'b0;
        d_imm   = 32'd0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        d_shift = 1'b0;
        // An all-zero word is SLL r0,r0,0 in MIPS; it is reported as NOP
        if (cmd_q == 32'd0) begin
            d_class = OC_NOP;
        end else begin
            case (opcode)
                6'b000000: begin
                    if (r_ok) begin
                        d_class = OC_ALU_R;
                        d_alu   = r_alu;
                        d_rd    = rd_f;
                        d_dest  = 1'b1;
                        use_rt  = 1'b1;
                        if (r_alu == ALU_SLL || r_alu == ALU_SRL) begin
                            d_shift = 1'b1;
                            d_imm   = {27'b0, cmd_q[10:6]};
                        end else begin
                            use_rs = 1'b1;
                        end
                    end else if (funct == 6'b001000) begin
                        d_class = OC_JREG;
                        use_rs  = 1'b1;
                    end else if (funct == 6'b001001) begin
                        d_class = OC_JREG;
                        d_rd    = rd_f;
                        d_dest  = 1'b1;
                        use_rs  = 1'b1;
                    end
                end
                6'b001001: begin
                    d_class = OC_ALU_I;
                    d_imm   = sext16;
                    d_rd    = rt_addr;
                    d_dest  = 1'b1;
                    use_rs  = 1'b1;
                end
                6'b001100, 6'b001101: begin
                    d_class = OC_ALU_I;
                    d_alu   = opcode[0] ? ALU_OR : ALU_AND;
                    d_imm   = zext16;
                    d_rd    = rt_addr;
                    d_dest  = 1'b1;
                    use_rs  = 1'b1;
                end
                6'b001111: begin
                    d_class = OC_LUI;
                    d_imm   = {cmd_q[15:0], 16'h0};
                    d_rd    = rt_addr;
                    d_dest  = 1'b1;
                end
                6'b100011: begin
                    d_class = OC_LOAD;
                    d_imm   = sext16;
                    d_rd    = rt_addr;
                    d_dest  = 1'b1;
                    use_rs  = 1'b1;
                end
                6'b101011: begin
                    d_class = OC_STORE;
                    d_imm   = sext16;
                    use_rs  = 1'b1;
                    use_rt  = 1'b1;
                end
                6'b000100, 6'b000101: begin
                    d_class = OC_BRANCH;
                    d_alu   = ALU_SUB;
                    d_imm   = sext16;
                    use_rs  = 1'b1;
                    use_rt  = 1'b1;
                end
                6'b000010: begin
                    d_class = OC_JUMP;
                    d_imm   = {6'b0, cmd_q[25:0]};
                end
                6'b000011: begin
                    d_class = OC_JUMP;
                    d_imm   = {6'b0, cmd_q[25:0]};
                    d_rd    = 5'd31;
                    d_dest  = 1'b1;
                end
                6'b110010: begin
                    d_class = OC_JUMP;
                    d_imm   = {{6{cmd_q[25]}}, cmd_q[25:0]};
                end
                default: ;
            endcase
        end
    end

    assign d_write = d_dest && (d_rd != 5'd0);

    // Same-cycle writeback both forwards the value and masks the busy bit
    assign fwd_rs = wb_enable && (wb_addr == rs_addr) && (rs_addr != 5'd0);
    assign fwd_rt = wb_enable && (wb_addr == rt_addr) && (rt_addr != 5'd0);
    assign rs_val = fwd_rs ? wb_data : rs_data;
    assign rt_val = fwd_rt ? wb_data : rt_data;

    assign hazard = (use_rs && (rs_addr != 5'd0) && busy[rs_addr] && !fwd_rs) ||
                    (use_rt && (rt_addr != 5'd0) && busy[rt_addr] && !fwd_rt);
    assign issue  = (state == CHECK) && !flush && !hazard;

    always_comb begin
        busy_n = busy;
        if (wb_enable) busy_n[wb_addr] = 1'b0;
        if (issue && d_write) busy_n[d_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_q     <= 32'd0;
            pc_q      <= 32'd0;
            busy      <= 32'd0;
            done      <= 1'b0;
            pcenable  <= 1'b0;
            next_pc   <= 32'd0;
            pc_out    <= RESET_PC;
            opclass   <= OC_NOP;
            alu_op    <= ALU_ADD;
            rd_addr   <= 5'd0;
            reg_write <= 1'b0;
            src_a     <= 32'd0;
            src_b     <= 32'd0;
            imm       <= 32'd0;
        end else begin
            done     <= 1'b0;
            pcenable <= 1'b0;
            busy     <= busy_n;
            case (state)
                IDLE: begin
                    if (enable && !flush) begin
                        pc_q  <= pc_in;
                        cmd_q <= command;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (!hazard) begin
                        done      <= 1'b1;
                        pc_out    <= pc_q;
                        opclass   <= d_class;
                        alu_op    <= d_alu;
                        rd_addr   <= d_rd;
                        reg_write <= d_write;
                        imm       <= d_imm;
                        src_a     <= d_shift ? rt_val : rs_val;
                        src_b     <= rt_val;
                        if (d_class == OC_JREG) begin
                            pcenable <= 1'b1;
                            next_pc  <= rs_val;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// hazard/flush/reset sequences, and random instructions against a reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        done;
    logic [31:0] pc_in;
    logic [31:0] command;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] pc_out;
    logic [3:0]  opclass;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] imm;
    logic        pcenable;
    logic [31:0] next_pc;

    logic [31:0] rf [32];
    logic        mbusy [32];
    int          tests = 0;
    int          fails = 0;

    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    always #5 clk = ~clk;

    decode_stage #(.RESET_PC(32'hfffffffc)) dut (
        .clk(clk), .rst(rst), .enable(enable), .done(done),
        .pc_in(pc_in), .command(command),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .pc_out(pc_out), .opclass(opclass), .alu_op(alu_op),
        .rd_addr(rd_addr), .reg_write(reg_write), .src_a(src_a), .src_b(src_b),
        .imm(imm), .pcenable(pcenable), .next_pc(next_pc)
    );

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] oc;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] rw;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pce;
    } vec_t;

    typedef struct packed {
        logic [3:0]  oc;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] imm;
        logic        use_rs;
        logic        use_rt;
        logic        shift;
    } mexp_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] cmd, input logic [31:0] pc);
        command = cmd;
        pc_in   = pc;
        enable  = 1'b1;
        step();
        enable  = 1'b0;
    endtask

    // Cycles from the CHECK entry to done; -1 if the bound expires
    task automatic wait_done(input int limit, output int n);
        bit seen = 1'b0;
        n = -1;
        for (int i = 1; i <= limit && !seen; i++) begin
            step();
            if (done === 1'b1) begin
                seen = 1'b1;
                n = i;
            end
        end
    endtask

    task automatic wb_pulse(input logic [4:0] a, input logic [31:0] d);
        wb_enable = 1'b1;
        wb_addr   = a;
        wb_data   = d;
        step();
        wb_enable = 1'b0;
        if (a != 5'd0) rf[a] = d;
    endtask

    task automatic check_reset_outputs();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pcenable", 32'(pcenable), 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_pc_out", pc_out, 32'hfffffffc);
        chk("rst_opclass", 32'(opclass), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rd", 32'(rd_addr), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_src_a", src_a, 32'd0);
        chk("rst_src_b", src_b, 32'd0);
        chk("rst_imm", imm, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    endtask

    function automatic mexp_t m_decode(input logic [31:0] c);
        mexp_t       e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] se;
        bit          dest;
        op   = c[31:26];
        fn   = c[5:0];
        se   = {{16{c[15]}}, c[15:0]};
        e    = '0;
        e.oc = 4'd15;
        dest = 1'b0;
        if (c == 32'd0) e.oc = 4'd0;
        else if (op == 6'd0) begin
            if (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a) begin
                e.oc = 4'd1; e.rd = c[15:11]; dest = 1'b1; e.use_rs = 1'b1; e.use_rt = 1'b1;
                e.alu = (fn == 6'h21) ? 4'd0 : (fn == 6'h23) ? 4'd1 : (fn == 6'h24) ? 4'd2 :
                        (fn == 6'h25) ? 4'd3 : 4'd4;
            end else if (fn == 6'h00 || fn == 6'h02) begin
                e.oc = 4'd1; e.rd = c[15:11]; dest = 1'b1; e.use_rt = 1'b1; e.shift = 1'b1;
                e.alu = (fn == 6'h00) ? 4'd5 : 4'd6;
                e.imm = 32'(c[10:6]);
            end else if (fn == 6'h08) begin
                e.oc = 4'd8; e.use_rs = 1'b1;
            end else if (fn == 6'h09) begin
                e.oc = 4'd8; e.use_rs = 1'b1; e.rd = c[15:11]; dest = 1'b1;
            end
        end else begin
            case (op)
                6'o11: begin e.oc = 4'd2; e.imm = se; e.rd = c[20:16]; dest = 1'b1; e.use_rs = 1'b1; end
                6'o14: begin e.oc = 4'd2; e.alu = 4'd2; e.imm = 32'(c[15:0]); e.rd = c[20:16]; dest = 1'b1; e.use_rs = 1'b1; end
                6'o15: begin e.oc = 4'd2; e.alu = 4'd3; e.imm = 32'(c[15:0]); e.rd = c[20:16]; dest = 1'b1; e.use_rs = 1'b1; end
                6'o17: begin e.oc = 4'd3; e.imm = {c[15:0], 16'h0}; e.rd = c[20:16]; dest = 1'b1; end
                6'o43: begin e.oc = 4'd4; e.imm = se; e.rd = c[20:16]; dest = 1'b1; e.use_rs = 1'b1; end
                6'o53: begin e.oc = 4'd5; e.imm = se; e.use_rs = 1'b1; e.use_rt = 1'b1; end
                6'o04, 6'o05: begin e.oc = 4'd6; e.alu = 4'd1; e.imm = se; e.use_rs = 1'b1; e.use_rt = 1'b1; end
                6'o02: begin e.oc = 4'd7; e.imm = 32'(c[25:0]); end
                6'o03: begin e.oc = 4'd7; e.imm = 32'(c[25:0]); e.rd = 5'd31; dest = 1'b1; end
                6'o62: begin e.oc = 4'd7; e.imm = {{6{c[25]}}, c[25:0]}; end
                default: ;
            endcase
        end
        e.rw = dest && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_cmd();
        logic [4:0]  rs, rt, rd;
        logic [15:0] i16;
        int          k;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        i16 = 16'($urandom);
        k   = $urandom_range(0, 9);
        case (k)
            0: begin
                case ($urandom_range(0, 4))
                    0: return {6'd0, rs, rt, rd, 5'd0, 6'h21};
                    1: return {6'd0, rs, rt, rd, 5'd0, 6'h23};
                    2: return {6'd0, rs, rt, rd, 5'd0, 6'h24};
                    3: return {6'd0, rs, rt, rd, 5'd0, 6'h25};
                    default: return {6'd0, rs, rt, rd, 5'd0, 6'h2a};
                endcase
            end
            1: return {6'd0, 5'd0, rt, rd, 5'($urandom), ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h02};
            2: begin
                case ($urandom_range(0, 2))
                    0: return {6'o11, rs, rt, i16};
                    1: return {6'o14, rs, rt, i16};
                    default: return {6'o15, rs, rt, i16};
                endcase
            end
            3: return {6'o17, 5'd0, rt, i16};
            4: return {6'o43, rs, rt, i16};
            5: return {6'o53, rs, rt, i16};
            6: return {($urandom_range(0, 1) == 0) ? 6'o04 : 6'o05, rs, rt, i16};
            7: return ($urandom_range(0, 1) == 0) ? {6'd0, rs, 15'd0, 6'h08} : {6'd0, rs, 5'd0, rd, 5'd0, 6'h09};
            8: begin
                case ($urandom_range(0, 2))
                    0: return {6'o02, 26'($urandom)};
                    1: return {6'o03, 26'($urandom)};
                    default: return {6'o62, 26'($urandom)};
                endcase
            end
            default: begin
                case ($urandom_range(0, 2))
                    0: return {6'o77, rs, rt, i16};
                    1: return {6'o10, rs, rt, i16};
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    vec_t vt [22];

    initial begin
        int          n;
        mexp_t       e;
        logic [31:0] cmd, pc, va, vb, ea;
        logic [4:0]  rs, rt;
        bit          haz, got;

        vt[0]  = '{32'h00221821, 5, 7, 1, 0, 3, 1, 32'h0, 5, 7, 0};
        vt[1]  = '{32'h2404ffff, 0, 32'h11, 2, 0, 4, 1, 32'hffffffff, 0, 32'h11, 0};
        vt[2]  = '{32'h3404ffff, 0, 32'h11, 2, 3, 4, 1, 32'h0000ffff, 0, 32'h11, 0};
        vt[3]  = '{32'h30258001, 32'h66, 32'h55, 2, 2, 5, 1, 32'h00008001, 32'h66, 32'h55, 0};
        vt[4]  = '{32'h00223023, 9, 4, 1, 1, 6, 1, 32'h0, 9, 4, 0};
        vt[5]  = '{32'h0022382a, 3, 8, 1, 4, 7, 1, 32'h0, 3, 8, 0};
        vt[6]  = '{32'h00024100, 0, 32'h0f, 1, 5, 8, 1, 32'd4, 32'h0f, 32'h0f, 0};
        vt[7]  = '{32'h00024fc2, 0, 32'h80000000, 1, 6, 9, 1, 32'd31, 32'h80000000, 32'h80000000, 0};
        vt[8]  = '{32'h3c0a1234, 0, 32'h77, 3, 0, 10, 1, 32'h12340000, 0, 32'h77, 0};
        vt[9]  = '{32'h8c2bfffc, 32'h1000, 32'h2, 4, 0, 11, 1, 32'hfffffffc, 32'h1000, 32'h2, 0};
        vt[10] = '{32'hac220008, 32'h200, 32'hab, 5, 0, 0, 0, 32'h8, 32'h200, 32'hab, 0};
        vt[11] = '{32'h1022ffff, 1, 2, 6, 1, 0, 0, 32'hffffffff, 1, 2, 0};
        vt[12] = '{32'h14220010, 4, 4, 6, 1, 0, 0, 32'h10, 4, 4, 0};
        vt[13] = '{32'h08000100, 0, 0, 7, 0, 0, 0, 32'h100, 0, 0, 0};
        vt[14] = '{32'h0c000040, 0, 0, 7, 0, 31, 1, 32'h40, 0, 0, 0};
        vt[15] = '{32'hcbfffffe, 32'h99, 32'h99, 7, 0, 0, 0, 32'hfffffffe, 32'h99, 32'h99, 0};
        vt[16] = '{32'h03e00008, 32'h400, 0, 8, 0, 0, 0, 32'h0, 32'h400, 0, 1};
        vt[17] = '{32'h00201009, 32'h80, 0, 8, 0, 2, 1, 32'h0, 32'h80, 0, 1};
        vt[18] = '{32'hfc000000, 0, 0, 15, 0, 0, 0, 32'h0, 0, 0, 0};
        vt[19] = '{32'h00000000, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0};
        vt[20] = '{32'h00220021, 5, 6, 1, 0, 0, 0, 32'h0, 5, 6, 0};
        vt[21] = '{32'h20010005, 0, 32'h33, 15, 0, 0, 0, 32'h0, 0, 32'h33, 0};

        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        enable = 1'b0; flush = 1'b0; wb_enable = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        pc_in = 32'd0; command = 32'd0;
        do_reset();
        check_reset_outputs();

        // Directed table with an idle scoreboard
        for (int v = 0; v < 22; v++) begin
            rs = vt[v].cmd[25:21];
            rt = vt[v].cmd[20:16];
            if (rs != 5'd0) rf[rs] = vt[v].rsv;
            if (rt != 5'd0) rf[rt] = vt[v].rtv;
            pc = 32'h1000 + 32'(v) * 4;
            issue(vt[v].cmd, pc);
            wait_done(10, n);
            chk($sformatf("v%0d_latency", v), 32'(n), 32'd1);
            if (n == 1) begin
                chk($sformatf("v%0d_opclass", v), 32'(opclass), vt[v].oc);
                chk($sformatf("v%0d_alu_op", v), 32'(alu_op), vt[v].alu);
                chk($sformatf("v%0d_rd", v), 32'(rd_addr), vt[v].rd);
                chk($sformatf("v%0d_reg_write", v), 32'(reg_write), vt[v].rw);
                chk($sformatf("v%0d_imm", v), imm, vt[v].imm);
                chk($sformatf("v%0d_src_a", v), src_a, vt[v].a);
                chk($sformatf("v%0d_src_b", v), src_b, vt[v].b);
                chk($sformatf("v%0d_pc_out", v), pc_out, pc);
                chk($sformatf("v%0d_pcenable", v), 32'(pcenable), vt[v].pce);
                if (vt[v].pce != 0) chk($sformatf("v%0d_next_pc", v), next_pc, vt[v].a);
                step();
                chk($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
                chk($sformatf("v%0d_pcenable_pulse", v), 32'(pcenable), 32'd0);
            end
            if (vt[v].rw != 0) wb_pulse(5'(vt[v].rd), $urandom);
        end

        // RAW hazard resolved by a same-cycle writeback
        rf[1] = 5; rf[2] = 7;
        issue(32'h00221821, 32'h2000);
        wait_done(10, n);
        chk("raw_first_latency", 32'(n), 32'd1);
        issue(32'h00622023, 32'h2004);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("raw_stall_done", 32'(done), 32'd0);
        end
        wb_pulse(5'd3, 32'h12);
        chk("raw_done", 32'(done), 32'd1);
        chk("raw_src_a", src_a, 32'h12);
        chk("raw_src_b", src_b, 32'd7);
        chk("raw_alu_op", 32'(alu_op), 32'd1);
        wb_pulse(5'd4, 32'h0);

        // Illegal word leaves the scoreboard untouched
        issue(32'hfc0a0000, 32'h3000);
        wait_done(10, n);
        chk("ill_latency", 32'(n), 32'd1);
        chk("ill_opclass", 32'(opclass), 32'd15);
        chk("ill_reg_write", 32'(reg_write), 32'd0);
        issue(32'h01420821, 32'h3004);
        wait_done(10, n);
        chk("ill_no_stall", 32'(n), 32'd1);
        wb_pulse(5'd1, 32'd5);

        // Flush during a stalled CHECK, then flush together with enable
        issue(32'h24050001, 32'h4000);
        wait_done(10, n);
        chk("fl_setup", 32'(n), 32'd1);
        issue(32'h00a23023, 32'h4004);
        step();
        chk("fl_stall", 32'(done), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_no_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_idle_done", 32'(done), 32'd0);
        end
        command = 32'h00221821; enable = 1'b1; flush = 1'b1;
        step();
        enable = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_en_done", 32'(done), 32'd0);
        end
        wb_pulse(5'd5, 32'h1);
        issue(32'h00c03821, 32'h4008);
        wait_done(10, n);
        chk("fl_r6_not_busy", 32'(n), 32'd1);
        wb_pulse(5'd7, 32'h0);

        // Reset during a stalled CHECK
        issue(32'h24050001, 32'h5000);
        wait_done(10, n);
        chk("rs_setup", 32'(n), 32'd1);
        issue(32'h00a23023, 32'h5004);
        step();
        chk("rs_stall", 32'(done), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rs_idle_done", 32'(done), 32'd0);
        end
        issue(32'h00c03821, 32'h5008);
        wait_done(10, n);
        chk("rs_r6_not_busy", 32'(n), 32'd1);
        issue(32'h00a23023, 32'h500c);
        wait_done(10, n);
        chk("rs_r5_cleared", 32'(n), 32'd1);

        // Random instructions and writebacks against the reference model
        do_reset();
        for (int t = 0; t < 200; t++) begin
            cmd = rand_cmd();
            e   = m_decode(cmd);
            rs  = cmd[25:21];
            rt  = cmd[20:16];
            pc  = $urandom & 32'hfffffffc;
            issue(cmd, pc);
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                wb_enable = ($urandom_range(0, 1) == 1);
                wb_data   = $urandom;
                if (e.use_rs && rs != 0 && mbusy[rs] && $urandom_range(0, 1) == 1) wb_addr = rs;
                else if (e.use_rt && rt != 0 && mbusy[rt]) wb_addr = rt;
                else if (e.use_rs && rs != 0 && mbusy[rs]) wb_addr = rs;
                else wb_addr = 5'($urandom_range(1, 7));
                haz = (e.use_rs && rs != 0 && mbusy[rs] && !(wb_enable && wb_addr == rs)) ||
                      (e.use_rt && rt != 0 && mbusy[rt] && !(wb_enable && wb_addr == rt));
                va = (wb_enable && wb_addr == rs && rs != 0) ? wb_data : rf[rs];
                vb = (wb_enable && wb_addr == rt && rt != 0) ? wb_data : rf[rt];
                ea = e.shift ? vb : va;
                step();
                if (wb_enable) begin
                    rf[wb_addr]    = wb_data;
                    mbusy[wb_addr] = 1'b0;
                end
                wb_enable = 1'b0;
                if (!haz && e.rw) mbusy[e.rd] = 1'b1;
                chk($sformatf("r%0d_done", t), 32'(done), 32'(!haz));
                if (!haz) begin
                    got = 1'b1;
                    chk($sformatf("r%0d_opclass", t), 32'(opclass), 32'(e.oc));
                    chk($sformatf("r%0d_alu_op", t), 32'(alu_op), 32'(e.alu));
                    chk($sformatf("r%0d_rd", t), 32'(rd_addr), 32'(e.rd));
                    chk($sformatf("r%0d_reg_write", t), 32'(reg_write), 32'(e.rw));
                    chk($sformatf("r%0d_imm", t), imm, e.imm);
                    chk($sformatf("r%0d_src_a", t), src_a, ea);
                    chk($sformatf("r%0d_src_b", t), src_b, vb);
                    chk($sformatf("r%0d_pc_out", t), pc_out, pc);
                    chk($sformatf("r%0d_pcenable", t), 32'(pcenable), 32'(e.oc == 4'd8));
                    if (e.oc == 4'd8) chk($sformatf("r%0d_next_pc", t), next_pc, va);
                end
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL r%0d_timeout: no done within 40 cycles, expected done", t);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
